fifo_rd_stream: RTL and testbench

//  Read-side drain stage for the dual-clock async FIFO, entirely in the rclk domain.

---
 rtl/fifo_rd_stream_pkg.sv | 24 ++
 rtl/skid_buf2.sv | 61 ++++++
 rtl/fifo_rd_stream.sv | 56 +++++
 tb/tb_fifo_rd_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the async-FIFO read-side drain stage.
package fifo_rd_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned OCC_WIDTH      = $clog2(SKID_DEPTH + 1);

    typedef logic [OCC_WIDTH-1:0] occ_t;

    typedef enum logic [1:0] {
        SKID_IDLE = 2'b00,
        SKID_POP  = 2'b01,
        SKID_PUSH = 2'b10,
        SKID_BOTH = 2'b11
    } skid_op_e;

    // Words already owed to the buffer (held + in flight - leaving now) must stay below depth.
    function automatic logic can_issue(input occ_t occ, input logic inflight, input logic pop);
        logic [OCC_WIDTH:0] pending;
        pending = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight} - {{OCC_WIDTH{1'b0}}, pop};
        return pending < (OCC_WIDTH + 1)'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO; entry 0 is always the head so dout needs no read mux.
module skid_buf2
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] ent0, ent1;
    logic                  do_pop, do_push;
    skid_op_e              op;

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != occ_t'(SKID_DEPTH)) || do_pop);
    assign dout    = ent0;

    always_comb begin
        op = skid_op_e'({do_push, do_pop});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else if (clear) begin
            occ <= '0;
        end else begin
            case (op)
                SKID_PUSH: begin
                    if (occ == '0) ent0 <= din;
                    else           ent1 <= din;
                    occ <= occ + 1'b1;
                end
                SKID_POP: begin
                    ent0 <= ent1;
                    occ  <= occ - 1'b1;
                end
                // Head leaves and the new word lands behind whatever remains.
                SKID_BOTH: begin
                    if (occ == occ_t'(1)) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                SKID_IDLE: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: turns the FIFO's empty/r_en/registered-data interface into valid/ready.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  ovf_err
);

    occ_t occ;
    logic inflight;
    logic pop;
    logic capture;

    assign m_valid   = (occ != '0);
    assign pop       = m_valid && m_ready;
    assign fifo_r_en = !rrst && !flush && !fifo_empty && can_issue(occ, inflight, pop);
    assign capture   = inflight && !flush;

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk  (rclk),
        .rst  (rrst),
        .clear(flush),
        .push (capture),
        .pop  (pop),
        .din  (fifo_data),
        .dout (m_data),
        .occ  (occ)
    );

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight <= 1'b0;
            rd_count <= '0;
            ovf_err  <= 1'b0;
        end else begin
            inflight <= fifo_r_en;
            if (pop) rd_count <= rd_count + 1'b1;
            if (capture && (occ == occ_t'(SKID_DEPTH)) && !pop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-backed source FIFO feeds the stage; delivered words are checked in order.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          rclk = 1'b0;
    logic          rrst, flush, fifo_empty, m_ready;
    logic          fifo_r_en, m_valid, ovf_err;
    logic [DW-1:0] fifo_data, m_data;
    logic [CW-1:0] rd_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            delivered = 0;
    logic          hold_empty;
    logic [7:0]    last_word;
    logic [7:0]    src[$];
    logic [7:0]    sb[$];

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_r_en (fifo_r_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .rd_count  (rd_count),
        .ovf_err   (ovf_err)
    );

    // One clock: called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        logic       reads;
        logic [7:0] w, exp_w;
        fifo_empty = hold_empty || (src.size() == 0);
        #1;
        if (fifo_empty) begin
            n_cmp++;
            if (fifo_r_en !== 1'b0) begin
                n_bad++;
                $display("FAIL underflow: fifo_r_en=%b want 0 while empty", fifo_r_en);
            end
        end
        if (!rrst && m_valid && m_ready) begin
            n_cmp++;
            delivered++;
            last_word = m_data;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL spurious: got %h want no word", m_data);
            end else begin
                exp_w = sb.pop_front();
                if (m_data !== exp_w) begin
                    n_bad++;
                    $display("FAIL order: got %h want %h", m_data, exp_w);
                end
            end
        end
        if (rrst || flush) sb.delete();
        reads = !rrst && fifo_r_en && !fifo_empty;
        @(posedge rclk);
        if (reads) begin
            w = src.pop_front();
            sb.push_back(w);
        end
        @(negedge rclk);
        if (reads) fifo_data = w;
    endtask

    task automatic do_reset();
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b1;
        cycle();
        rrst = 1'b0;
        src.delete();
        sb.delete();
        delivered = 0;
    endtask

    task automatic test_reset();
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;
        src.push_back(8'hAA);
        src.push_back(8'hBB);
        for (int i = 0; i < 2; i++) begin
            cycle();
            #1;
            n_cmp += 5;
            if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
            if (m_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
            if (m_data !== 8'h00)   begin n_bad++; $display("FAIL reset_data: got %h want 00", m_data); end
            if (rd_count !== 4'd0)  begin n_bad++; $display("FAIL reset_count: got %0d want 0", rd_count); end
            if (ovf_err !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
        end
        rrst = 1'b0;
        src.delete();
    endtask

    task automatic test_stream();
        logic exp_v;
        do_reset();
        hold_empty = 1'b0; m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        for (int t = 0; t < 12; t++) begin
            fifo_empty = (src.size() == 0);
            #1;
            exp_v = (t >= 2) && (t <= 9);
            n_cmp++;
            if (m_valid !== exp_v) begin
                n_bad++;
                $display("FAIL stream_valid t=%0d: got %b want %b", t, m_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (m_data !== 8'(t - 1)) begin
                    n_bad++;
                    $display("FAIL stream_data t=%0d: got %h want %h", t, m_data, 8'(t - 1));
                end
            end
            cycle();
        end
        #1;
        n_cmp += 2;
        if (rd_count !== 4'd8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", rd_count); end
        if (delivered != 8)    begin n_bad++; $display("FAIL stream_delivered: got %0d want 8", delivered); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bp_exp[3];
        bp_exp = '{8'h11, 8'h22, 8'h33};
        do_reset();
        hold_empty = 1'b0; m_ready = 1'b0;
        src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
        for (int t = 0; t < 3; t++) cycle();
        for (int t = 3; t < 6; t++) begin
            fifo_empty = (src.size() == 0);
            #1;
            n_cmp += 3;
            if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL bp_r_en t=%0d: got %b want 0", t, fifo_r_en); end
            if (m_valid !== 1'b1)   begin n_bad++; $display("FAIL bp_valid t=%0d: got %b want 1", t, m_valid); end
            if (m_data !== 8'h11)   begin n_bad++; $display("FAIL bp_hold t=%0d: got %h want 11", t, m_data); end
            cycle();
        end
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fifo_empty = (src.size() == 0);
            #1;
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== bp_exp[k]) begin
                n_bad++;
                $display("FAIL bp_release k=%0d: got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, bp_exp[k]);
            end
            cycle();
        end
        #1;
        n_cmp += 2;
        if (rd_count !== 4'd3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", rd_count); end
        if (ovf_err !== 1'b0)  begin n_bad++; $display("FAIL bp_ovf: got %b want 0", ovf_err); end
    endtask

    task automatic test_empty_toggle();
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(8'(8'h40 + i));
        for (int t = 0; t < 80; t++) begin
            hold_empty = t[0];
            m_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        hold_empty = 1'b0; m_ready = 1'b1;
        for (int t = 0; t < 8; t++) cycle();
        #1;
        n_cmp += 4;
        if (delivered != 16)   begin n_bad++; $display("FAIL toggle_delivered: got %0d want 16", delivered); end
        if (sb.size() != 0)    begin n_bad++; $display("FAIL toggle_leftover: got %0d want 0", sb.size()); end
        if (rd_count !== 4'd0) begin n_bad++; $display("FAIL toggle_count: got %0d want 0", rd_count); end
        if (ovf_err !== 1'b0)  begin n_bad++; $display("FAIL toggle_ovf: got %b want 0", ovf_err); end
    endtask

    task automatic test_flush();
        do_reset();
        hold_empty = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) src.push_back(8'(8'h50 + i));
        cycle(); cycle();
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h51) begin
            n_bad++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=51", m_valid, m_data);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        n_cmp += 2;
        if (m_valid !== 1'b0)  begin n_bad++; $display("FAIL flush_valid: got %b want 0", m_valid); end
        if (rd_count !== 4'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", rd_count); end
        m_ready = 1'b1; delivered = 0;
        cycle(); cycle();
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h53) begin
            n_bad++; $display("FAIL flush_next: got v=%b d=%h want v=1 d=53", m_valid, m_data);
        end
        for (int t = 0; t < 6; t++) cycle();
        #1;
        n_cmp += 2;
        if (delivered != 4)    begin n_bad++; $display("FAIL flush_delivered: got %0d want 4", delivered); end
        if (rd_count !== 4'd4) begin n_bad++; $display("FAIL flush_count2: got %0d want 4", rd_count); end

        // Full buffer with a pop in the flush cycle: that pop still counts.
        m_ready = 1'b0;
        src.push_back(8'h61); src.push_back(8'h62); src.push_back(8'h63);
        cycle(); cycle(); cycle();
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h61) begin
            n_bad++; $display("FAIL flush_full: got v=%b d=%h want v=1 d=61", m_valid, m_data);
        end
        m_ready = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; m_ready = 1'b0;
        #1;
        n_cmp += 3;
        if (m_valid !== 1'b0)  begin n_bad++; $display("FAIL flush2_valid: got %b want 0", m_valid); end
        if (rd_count !== 4'd5) begin n_bad++; $display("FAIL flush2_count: got %0d want 5", rd_count); end
        if (ovf_err !== 1'b0)  begin n_bad++; $display("FAIL flush2_ovf: got %b want 0", ovf_err); end
        m_ready = 1'b1; delivered = 0;
        for (int t = 0; t < 5; t++) cycle();
        #1;
        n_cmp += 3;
        if (delivered != 1)      begin n_bad++; $display("FAIL flush2_delivered: got %0d want 1", delivered); end
        if (last_word !== 8'h63) begin n_bad++; $display("FAIL flush2_word: got %h want 63", last_word); end
        if (rd_count !== 4'd6)   begin n_bad++; $display("FAIL flush2_count2: got %0d want 6", rd_count); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        hold_empty = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) src.push_back(8'(8'h80 + i));
        for (int t = 0; t < 22; t++) cycle();
        #1;
        n_cmp += 2;
        if (rd_count !== 4'd1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", rd_count); end
        if (delivered != 17)   begin n_bad++; $display("FAIL wrap_delivered: got %0d want 17", delivered); end
        for (int i = 0; i < 5; i++) src.push_back(8'(8'hA0 + i));
        cycle(); cycle(); cycle();
        #1;
        n_cmp++;
        if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid: got %b want 1", m_valid); end
        rrst = 1'b1;
        cycle();
        rrst = 1'b0; hold_empty = 1'b1; m_ready = 1'b0;
        fifo_empty = 1'b1;
        #1;
        n_cmp += 5;
        if (m_valid !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00)   begin n_bad++; $display("FAIL mid_rst_data: got %h want 00", m_data); end
        if (rd_count !== 4'd0)  begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", rd_count); end
        if (ovf_err !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_ovf: got %b want 0", ovf_err); end
        if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_r_en: got %b want 0", fifo_r_en); end
        cycle(); cycle();
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_inflight: got %b want 0", m_valid); end
        src.delete();
    endtask

    initial begin
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0; last_word = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_toggle();
        test_flush();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
